// File: rtl/skinny_dec_fsm.sv
// Round controller for SKINNY decryption: a forward tweakey-schedule pass, then ROUNDS
// inverse rounds. Consecutive blocks run back to back until `last` is seen.
module skinny_dec_fsm #(
    parameter int ROUNDS = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         last,
    input  logic [127:0] pt_in,
    output logic         load,
    output logic         tk_fwd,
    output logic         round_inv,
    output logic [5:0]   rc_idx,
    output logic         done,
    output logic         busy,
    output logic [127:0] pt_out,
    output logic         pt_valid
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);
    localparam logic [5:0]    RC_MAX   = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TK_FWD = 2'd1,
        S_DEC    = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   next_cnt_s;
    logic            final_s;

    assign final_s = (cnt_r == LAST_CNT);
    assign busy    = (state_r != S_IDLE);

    // State and round-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_TK_FWD;
                    next_cnt_s   = '0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_TK_FWD: begin
                if (final_s) begin
                    next_state_s = S_DEC;
                    next_cnt_s   = '0;
                end else begin
                    next_cnt_s   = cnt_r + CW'(1);
                end
            end
            S_DEC: begin
                if (final_s) begin
                    // The next block's load overlaps this cycle, so no idle bubble
                    next_state_s = last ? S_IDLE : S_TK_FWD;
                    next_cnt_s   = '0;
                end else begin
                    next_cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                next_state_s = S_IDLE;
                next_cnt_s   = '0;
            end
        endcase
    end

    // Datapath strobes and round-constant index
    always_comb begin
        load      = 1'b0;
        tk_fwd    = 1'b0;
        round_inv = 1'b0;
        done      = 1'b0;
        rc_idx    = 6'd0;
        case (state_r)
            S_IDLE: begin
                load = start;
            end
            S_TK_FWD: begin
                tk_fwd = 1'b1;
                rc_idx = 6'(cnt_r);
            end
            S_DEC: begin
                round_inv = 1'b1;
                rc_idx    = RC_MAX - 6'(cnt_r);
                done      = final_s;
                load      = final_s & ~last;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // Plaintext capture register and its valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pt_out   <= 128'd0;
            pt_valid <= 1'b0;
        end else begin
            pt_valid <= done;
            if (done) begin
                pt_out <= pt_in;
            end else begin
                pt_out <= pt_out;
            end
        end
    end

endmodule

// File: tb/tb_skinny_dec_fsm.sv
// Self-checking bench for skinny_dec_fsm: a 40-round instance and a 2-round instance,
// both checked every cycle against a block-timeline reference model.
module tb_skinny_dec_fsm;

    localparam int RA = 40;
    localparam int RB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a, start_a, last_a;
    logic [127:0] pt_in_a;
    logic         load_a, tk_fwd_a, round_inv_a, done_a, busy_a, pt_valid_a;
    logic [5:0]   rc_idx_a;
    logic [127:0] pt_out_a;

    logic         reset_b, start_b, last_b;
    logic [127:0] pt_in_b;
    logic         load_b, tk_fwd_b, round_inv_b, done_b, busy_b, pt_valid_b;
    logic [5:0]   rc_idx_b;
    logic [127:0] pt_out_b;

    skinny_dec_fsm #(.ROUNDS(RA)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .last(last_a), .pt_in(pt_in_a),
        .load(load_a), .tk_fwd(tk_fwd_a), .round_inv(round_inv_a), .rc_idx(rc_idx_a),
        .done(done_a), .busy(busy_a), .pt_out(pt_out_a), .pt_valid(pt_valid_a)
    );

    skinny_dec_fsm #(.ROUNDS(RB)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .last(last_b), .pt_in(pt_in_b),
        .load(load_b), .tk_fwd(tk_fwd_b), .round_inv(round_inv_b), .rc_idx(rc_idx_b),
        .done(done_b), .busy(busy_b), .pt_out(pt_out_b), .pt_valid(pt_valid_b)
    );

    int tests = 0;
    int fails = 0;

    // Model state: position within the current block's timeline (-1 = idle)
    int           pos_a = -1;
    int           pos_b = -1;
    logic [127:0] mpt_a = 128'd0;
    logic [127:0] mpt_b = 128'd0;
    logic         mval_a = 1'b0;
    logic         mval_b = 1'b0;

    logic [10:0]  exp_a, exp_b, obs_a, obs_b;
    logic [127:0] exp_pt_a, exp_pt_b;
    logic         exp_val_a, exp_val_b;

    assign obs_a = {load_a, tk_fwd_a, round_inv_a, done_a, busy_a, rc_idx_a};
    assign obs_b = {load_b, tk_fwd_b, round_inv_b, done_b, busy_b, rc_idx_b};

    // Block timeline: t=0 load, 1..r forward schedule, r+1..2r inverse rounds, done at 2r
    function automatic logic [10:0] ref_out(int r, int pos, logic st, logic lst);
        logic ld, tk, ri, dn, bz;
        int   rc;
        ld = 1'b0; tk = 1'b0; ri = 1'b0; dn = 1'b0; bz = 1'b0; rc = 0;
        if (pos < 0) begin
            ld = st;
        end else if (pos <= r) begin
            tk = 1'b1; bz = 1'b1; rc = pos - 1;
        end else begin
            ri = 1'b1; bz = 1'b1; rc = 2 * r - pos;
            dn = (pos == 2 * r);
            ld = dn && !lst;
        end
        return {ld, tk, ri, dn, bz, 6'(rc)};
    endfunction

    function automatic int ref_next(int r, int pos, logic rst, logic st, logic lst);
        if (rst) return -1;
        if (pos < 0) return st ? 1 : -1;
        if (pos == 2 * r) return lst ? -1 : 1;
        return pos + 1;
    endfunction

    // Drive one cycle on both instances, compute expectations, advance the model
    task automatic tick(input logic st_a, input logic lst_a, input logic rst_a,
                        input logic st_b, input logic lst_b, input logic rst_b);
        @(negedge clk);
        start_a = st_a; last_a = lst_a; reset_a = rst_a;
        pt_in_a = {$urandom, $urandom, $urandom, $urandom};
        start_b = st_b; last_b = lst_b; reset_b = rst_b;
        pt_in_b = {$urandom, $urandom, $urandom, $urandom};

        exp_a = ref_out(RA, pos_a, st_a, lst_a);
        exp_pt_a = mpt_a; exp_val_a = mval_a;
        if (rst_a) begin mval_a = 1'b0; mpt_a = 128'd0; end
        else begin mval_a = exp_a[7]; if (exp_a[7]) mpt_a = pt_in_a; end
        pos_a = ref_next(RA, pos_a, rst_a, st_a, lst_a);

        exp_b = ref_out(RB, pos_b, st_b, lst_b);
        exp_pt_b = mpt_b; exp_val_b = mval_b;
        if (rst_b) begin mval_b = 1'b0; mpt_b = 128'd0; end
        else begin mval_b = exp_b[7]; if (exp_b[7]) mpt_b = pt_in_b; end
        pos_b = ref_next(RB, pos_b, rst_b, st_b, lst_b);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b0, (c < 1), 1'b0, 1'b0, (c < 1));
            tests += 3;
            if (obs_a !== 11'd0 || obs_b !== 11'd0) begin
                fails++;
                $display("FAIL reset_strobes c=%0d got a=%h b=%h want 0", c, obs_a, obs_b);
            end
            if (pt_out_a !== 128'd0 || pt_valid_a !== 1'b0) begin
                fails++;
                $display("FAIL reset_pt_a got %h/%b want 0/0", pt_out_a, pt_valid_a);
            end
            if (pt_out_b !== 128'd0 || pt_valid_b !== 1'b0) begin
                fails++;
                $display("FAIL reset_pt_b got %h/%b want 0/0", pt_out_b, pt_valid_b);
            end
        end
    endtask

    task automatic test_single_block();
        int done_at = -1, val_at = -1, loads = 0;
        for (int c = 0; c <= 90; c++) begin
            tick((c == 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tests += 2;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL single_strobes c=%0d got %h want %h", c, obs_a, exp_a);
            end
            if (pt_out_a !== exp_pt_a || pt_valid_a !== exp_val_a) begin
                fails++;
                $display("FAIL single_pt c=%0d got %h/%b want %h/%b", c, pt_out_a, pt_valid_a, exp_pt_a, exp_val_a);
            end
            if (done_a) done_at = c;
            if (pt_valid_a) val_at = c;
            if (load_a) loads++;
        end
        tests++;
        if (done_at != 80 || val_at != 81 || loads != 1) begin
            fails++;
            $display("FAIL single_timing got done=%0d valid=%0d loads=%0d want 80/81/1", done_at, val_at, loads);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int loads[$];
        logic lst;
        for (int c = 0; c <= 250; c++) begin
            if (c == 240) lst = 1'b1;
            else if (c == 80 || c == 160) lst = 1'b0;
            else lst = 1'($urandom);
            tick((c == 0), lst, 1'b0, 1'b0, 1'b0, 1'b0);
            tests += 2;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL b2b_strobes c=%0d got %h want %h", c, obs_a, exp_a);
            end
            if (pt_out_a !== exp_pt_a || pt_valid_a !== exp_val_a) begin
                fails++;
                $display("FAIL b2b_pt c=%0d got %h/%b want %h/%b", c, pt_out_a, pt_valid_a, exp_pt_a, exp_val_a);
            end
            if (done_a) dones.push_back(c);
            if (load_a) loads.push_back(c);
            if (c >= 1 && c <= 240 && busy_a !== 1'b1) begin
                fails++;
                $display("FAIL b2b_busy c=%0d got %b want 1", c, busy_a);
            end
            tests++;
        end
        tests++;
        if (dones.size() != 3 || loads.size() != 3 || dones[0] != 80 || dones[1] != 160 ||
            dones[2] != 240 || loads[0] != 0 || loads[1] != 80 || loads[2] != 160) begin
            fails++;
            $display("FAIL b2b_timing got %0d dones %0d loads want done 80/160/240 load 0/80/160",
                     dones.size(), loads.size());
        end
    endtask

    task automatic test_start_busy();
        int done_at = -1, loads = 0;
        for (int c = 0; c <= 90; c++) begin
            tick((c == 0 || c == 10 || c == 50), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL start_busy c=%0d got %h want %h", c, obs_a, exp_a);
            end
            if (done_a) done_at = c;
            if (load_a) loads++;
        end
        tests++;
        if (done_at != 80 || loads != 1) begin
            fails++;
            $display("FAIL start_busy_timing got done=%0d loads=%0d want 80/1", done_at, loads);
        end
    endtask

    task automatic test_reset_mid();
        int dones[$];
        for (int c = 0; c <= 150; c++) begin
            tick((c == 0 || c == 62), 1'b1, (c == 60), 1'b0, 1'b0, 1'b0);
            tests += 2;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL reset_mid_strobes c=%0d got %h want %h", c, obs_a, exp_a);
            end
            if (pt_out_a !== exp_pt_a || pt_valid_a !== exp_val_a) begin
                fails++;
                $display("FAIL reset_mid_pt c=%0d got %h/%b want %h/%b", c, pt_out_a, pt_valid_a, exp_pt_a, exp_val_a);
            end
            if (c == 61) begin
                tests++;
                if (busy_a !== 1'b0 || pt_valid_a !== 1'b0 || pt_out_a !== 128'd0) begin
                    fails++;
                    $display("FAIL reset_mid_idle got busy=%b valid=%b pt=%h want 0/0/0", busy_a, pt_valid_a, pt_out_a);
                end
            end
            if (done_a) dones.push_back(c);
        end
        tests++;
        if (dones.size() != 1 || dones[0] != 142) begin
            fails++;
            $display("FAIL reset_mid_done got %0d dones (first %0d) want one at 142",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
    endtask

    task automatic test_last_sampling();
        for (int c = 0; c <= 85; c++) begin
            tick((c == 0), (c == 80) ? 1'b1 : ((c < 60) ? 1'(c % 2) : 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs_a !== exp_a) begin
                fails++;
                $display("FAIL last_sampling c=%0d got %h want %h", c, obs_a, exp_a);
            end
            if (c == 81) begin
                tests++;
                if (busy_a !== 1'b0) begin
                    fails++;
                    $display("FAIL last_idle got busy=%b want 0", busy_a);
                end
            end
        end
    endtask

    task automatic test_min_rounds();
        int done_at = -1, val_at = -1;
        for (int c = 0; c <= 8; c++) begin
            tick(1'b0, 1'b0, 1'b0, (c == 0), 1'b1, 1'b0);
            tests += 2;
            if (obs_b !== exp_b) begin
                fails++;
                $display("FAIL min_rounds_strobes c=%0d got %h want %h", c, obs_b, exp_b);
            end
            if (pt_out_b !== exp_pt_b || pt_valid_b !== exp_val_b) begin
                fails++;
                $display("FAIL min_rounds_pt c=%0d got %h/%b want %h/%b", c, pt_out_b, pt_valid_b, exp_pt_b, exp_val_b);
            end
            if (c == 3 || c == 4) begin
                tests++;
                if (round_inv_b !== 1'b1 || rc_idx_b !== 6'(4 - c)) begin
                    fails++;
                    $display("FAIL min_rounds_rc c=%0d got ri=%b rc=%0d want 1/%0d", c, round_inv_b, rc_idx_b, 4 - c);
                end
            end
            if (done_b) done_at = c;
            if (pt_valid_b) val_at = c;
        end
        tests++;
        if (done_at != 4 || val_at != 5) begin
            fails++;
            $display("FAIL min_rounds_timing got done=%0d valid=%0d want 4/5", done_at, val_at);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            tick(($urandom % 4) == 0, 1'($urandom), ($urandom % 97) == 0,
                 ($urandom % 3) == 0, 1'($urandom), ($urandom % 41) == 0);
            tests += 2;
            if (obs_a !== exp_a || pt_out_a !== exp_pt_a || pt_valid_a !== exp_val_a) begin
                fails++;
                $display("FAIL random_a c=%0d got %h/%b want %h/%b", c, obs_a, pt_valid_a, exp_a, exp_val_a);
            end
            if (obs_b !== exp_b || pt_out_b !== exp_pt_b || pt_valid_b !== exp_val_b) begin
                fails++;
                $display("FAIL random_b c=%0d got %h/%b want %h/%b", c, obs_b, pt_valid_b, exp_b, exp_val_b);
            end
        end
    endtask

    initial begin
        reset_a = 1'b1; start_a = 1'b0; last_a = 1'b0; pt_in_a = 128'd0;
        reset_b = 1'b1; start_b = 1'b0; last_b = 1'b0; pt_in_b = 128'd0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_start_busy();
        test_reset_mid();
        test_last_sampling();
        test_min_rounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached without completing the run");
        $fatal(1, "timeout");
    end

endmodule
